// File: rtl/rf_ctrl_pkg.sv
// Shared types and constants for the register-file write-port controller.
package rf_ctrl_pkg;

    typedef enum logic {INIT, ARB} state_e;

    localparam int unsigned REG_COUNT = 32;
    localparam int unsigned ADDR_W    = 5;
    localparam int unsigned SP_REG    = 29;
    localparam int unsigned ZERO_REG  = 0;

    function automatic logic is_sp_reg(input logic [ADDR_W-1:0] a);
        return a == ADDR_W'(SP_REG);
    endfunction

    function automatic logic is_zero_reg(input logic [ADDR_W-1:0] a);
        return a == ADDR_W'(ZERO_REG);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: first requester at or after the priority pointer wins,
// and the pointer moves just past the winner on each grant.
module rr_arbiter #(
    parameter int unsigned NREQ = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [NREQ-1:0] req_i,
    input  logic            en_i,
    output logic [NREQ-1:0] gnt_o,
    output logic            upd_o
);

    localparam int unsigned PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [PTR_W-1:0] ptr_q, ptr_d;

    always_comb begin
        int unsigned      idx;
        logic [PTR_W-1:0] sel;
        gnt_o = '0;
        upd_o = 1'b0;
        ptr_d = ptr_q;
        idx   = 0;
        sel   = '0;
        if (en_i) begin
            for (int unsigned k = 0; k < NREQ; k++) begin
                idx = 32'(ptr_q) + k;
                if (idx >= NREQ) idx = idx - NREQ;
                sel = PTR_W'(idx);
                if (!upd_o && req_i[sel]) begin
                    gnt_o[sel] = 1'b1;
                    upd_o      = 1'b1;
                    ptr_d      = (idx == NREQ - 1) ? '0 : PTR_W'(idx + 1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr_q <= '0;
        end else if (upd_o) begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/regfile_write_ctrl.sv
// Register-file write-port owner: optional reset-time init walk, then round-robin
// sharing between NREQ writeback requesters. Init walk enabled by RF_WRITE_CTRL_INIT_EN.
module regfile_write_ctrl
    import rf_ctrl_pkg::*;
#(
    parameter int unsigned N    = 32,
    parameter int unsigned NREQ = 4
`ifdef RF_WRITE_CTRL_INIT_EN
    ,
    parameter logic [N-1:0] SP_INIT = N'(252)
`endif
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NREQ-1:0]        req_valid_i,
    input  logic [NREQ*ADDR_W-1:0] req_rd_i,
    input  logic [NREQ*N-1:0]      req_data_i,
    output logic [NREQ-1:0]        req_ready_o,
    output logic                   Reg_Write_o,
    output logic [ADDR_W-1:0]      Write_Register_o,
    output logic [N-1:0]           Write_Data_o,
    output logic [NREQ-1:0]        grant_o,
    output logic                   init_done_o
);

    logic [NREQ-1:0]   gnt;
    logic              upd;
    logic              arb_en;
    logic [ADDR_W-1:0] sel_rd;
    logic [N-1:0]      sel_data;

    logic              we_d, we_q;
    logic [ADDR_W-1:0] waddr_d, waddr_q;
    logic [N-1:0]      wdata_d, wdata_q;
    logic [NREQ-1:0]   grant_d, grant_q;

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .clk   (clk),
        .reset (reset),
        .req_i (req_valid_i),
        .en_i  (arb_en),
        .gnt_o (gnt),
        .upd_o (upd)
    );

    // Ready is forced low while reset is held so no handshake completes in reset.
    assign req_ready_o = reset ? gnt : '0;

    // Route the winner's destination and data to the write port.
    always_comb begin
        sel_rd   = '0;
        sel_data = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (gnt[i]) begin
                sel_rd   = req_rd_i[i*ADDR_W +: ADDR_W];
                sel_data = req_data_i[i*N +: N];
            end
        end
    end

`ifdef RF_WRITE_CTRL_INIT_EN
    state_e            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              done_q, done_d;

    assign arb_en      = (state_q == ARB);
    assign init_done_o = done_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= INIT;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end
`else
    assign arb_en      = 1'b1;
    assign init_done_o = 1'b1;
`endif

    // Next-state and write-port decision for this cycle.
    always_comb begin
        we_d    = 1'b0;
        waddr_d = '0;
        wdata_d = '0;
        grant_d = '0;
`ifdef RF_WRITE_CTRL_INIT_EN
        state_d = state_q;
        cnt_d   = cnt_q;
        done_d  = done_q;
        unique case (state_q)
            INIT: begin
                we_d    = 1'b1;
                waddr_d = cnt_q;
                wdata_d = is_sp_reg(cnt_q) ? SP_INIT : '0;
                cnt_d   = cnt_q + ADDR_W'(1);
                if (cnt_q == ADDR_W'(REG_COUNT - 1)) begin
                    state_d = ARB;
                    done_d  = 1'b1;
                end
            end
            ARB:     ;
            default: state_d = INIT;
        endcase
`endif
        // Accepted writes to r0 complete the handshake but never reach the file.
        if (upd) begin
            grant_d = gnt;
            we_d    = !is_zero_reg(sel_rd);
            waddr_d = sel_rd;
            wdata_d = sel_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
            grant_q <= '0;
        end else begin
            we_q    <= we_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            grant_q <= grant_d;
        end
    end

    assign Reg_Write_o      = we_q;
    assign Write_Register_o = waddr_q;
    assign Write_Data_o     = wdata_q;
    assign grant_o          = grant_q;

endmodule

// File: tb/tb_regfile_write_ctrl.sv
// Directed bench for regfile_write_ctrl (NREQ=4, N=32); covers both
// RF_WRITE_CTRL_INIT_EN builds.
module tb_regfile_write_ctrl;

    logic         clk;
    logic         reset;
    logic [3:0]   req_valid;
    logic [19:0]  req_rd;
    logic [127:0] req_data;
    logic [3:0]   req_ready;
    logic         we;
    logic [4:0]   waddr;
    logic [31:0]  wdata;
    logic [3:0]   grant;
    logic         done;

    int n_cmp = 0;
    int n_err = 0;

    regfile_write_ctrl #(.N(32), .NREQ(4)) dut (
        .clk              (clk),
        .reset            (reset),
        .req_valid_i      (req_valid),
        .req_rd_i         (req_rd),
        .req_data_i       (req_data),
        .req_ready_o      (req_ready),
        .Reg_Write_o      (we),
        .Write_Register_o (waddr),
        .Write_Data_o     (wdata),
        .grant_o          (grant),
        .init_done_o      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int i, input logic [4:0] rd, input logic [31:0] d);
        req_valid[i]        = 1'b1;
        req_rd[i*5 +: 5]    = rd;
        req_data[i*32 +: 32] = d;
    endtask

    // One isolated request: ready checked in its cycle, write checked the next.
    task automatic single(input string tag, input int i, input logic [4:0] rd,
                          input logic [31:0] d, input logic [3:0] exp_gnt, input logic exp_we);
        @(posedge clk); #1;
        set_req(i, rd, d);
        @(negedge clk);
        chk({tag, "_ready"}, 32'(req_ready), 32'(exp_gnt));
        @(posedge clk); #1;
        req_valid = '0;
        @(negedge clk);
        chk({tag, "_we"}, 32'(we), 32'(exp_we));
        if (exp_we) begin
            chk({tag, "_waddr"}, 32'(waddr), 32'(rd));
            chk({tag, "_wdata"}, wdata, d);
        end
        chk({tag, "_grant"}, 32'(grant), 32'(exp_gnt));
    endtask

    initial begin
        reset     = 1'b0;
        req_valid = '0;
        req_rd    = '0;
        req_data  = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_we", 32'(we), 0);
        chk("rst_waddr", 32'(waddr), 0);
        chk("rst_wdata", wdata, 0);
        chk("rst_grant", 32'(grant), 0);
        chk("rst_ready", 32'(req_ready), 0);
`ifdef RF_WRITE_CTRL_INIT_EN
        chk("rst_done", 32'(done), 0);
        // Abort the walk at counter 10 and make sure everything clears at once.
        @(posedge clk); #1;
        reset = 1'b1;
        repeat (11) @(negedge clk);
        chk("init10_waddr", 32'(waddr), 9);
        #2 reset = 1'b0;
        #1;
        chk("abort_we", 32'(we), 0);
        chk("abort_waddr", 32'(waddr), 0);
        chk("abort_wdata", wdata, 0);
        chk("abort_done", 32'(done), 0);
        @(posedge clk);
`else
        chk("rst_done", 32'(done), 1);
`endif
        // Release reset: this cycle is cycle 0; req0 waits with rd=7.
        @(posedge clk); #1;
        reset = 1'b1;
        set_req(0, 5'd7, 32'hA5A5_A5A5);
`ifdef RF_WRITE_CTRL_INIT_EN
        @(negedge clk);
        chk("c0_we", 32'(we), 0);
        chk("c0_ready", 32'(req_ready), 0);
        for (int c = 1; c <= 32; c++) begin
            @(negedge clk);
            chk("walk_we", 32'(we), 1);
            chk("walk_waddr", 32'(waddr), 32'(c - 1));
            chk("walk_wdata", wdata, (c - 1 == 29) ? 32'd252 : 32'd0);
            chk("walk_done", 32'(done), (c == 32) ? 32'd1 : 32'd0);
            if (c < 32) chk("walk_ready", 32'(req_ready), 0);
        end
`else
        @(negedge clk);
`endif
        chk("first_ready", 32'(req_ready), 32'b0001);
        chk("first_done", 32'(done), 1);
        @(posedge clk); #1;
        req_valid = '0;
        @(negedge clk);
        chk("first_we", 32'(we), 1);
        chk("first_waddr", 32'(waddr), 7);
        chk("first_wdata", wdata, 32'hA5A5_A5A5);
        chk("first_grant", 32'(grant), 32'b0001);

        // Pointer is now 1.
        single("req2", 2, 5'd5, 32'hDEAD_BEEF, 4'b0100, 1'b1);
        single("req3", 3, 5'd9, 32'h0BAD_F00D, 4'b1000, 1'b1);

        // Pointer back at 0: all four stay valid, grants rotate 0,1,2,3,0.
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) set_req(i, 5'(i + 1), 32'(256 + i));
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("rr_ready", 32'(req_ready), 32'd1 << (c % 4));
            if (c > 0) begin
                chk("rr_grant", 32'(grant), 32'd1 << ((c - 1) % 4));
                chk("rr_waddr", 32'(waddr), 32'((c - 1) % 4 + 1));
                chk("rr_wdata", wdata, 32'(256 + (c - 1) % 4));
            end
        end
        @(posedge clk); #1;
        req_valid = '0;
        @(negedge clk);
        chk("rr_last_grant", 32'(grant), 32'b0001);
        chk("rr_last_waddr", 32'(waddr), 1);

        // Pointer is 1: write to r0 is accepted but suppressed.
        single("rd0", 1, 5'd0, 32'h0000_1234, 4'b0010, 1'b0);

        // Nothing valid: no grant, no write.
        @(posedge clk); #1;
        @(negedge clk);
        chk("idle_ready", 32'(req_ready), 0);
        @(negedge clk);
        chk("idle_we", 32'(we), 0);
        chk("idle_grant", 32'(grant), 0);

        // Pointer is 2: two writes to r12 land in grant order.
        @(posedge clk); #1;
        set_req(2, 5'd12, 32'h11);
        set_req(3, 5'd12, 32'h22);
        @(negedge clk);
        chk("same_ready0", 32'(req_ready), 32'b0100);
        @(posedge clk); #1;
        req_valid[2] = 1'b0;
        @(negedge clk);
        chk("same_wdata0", wdata, 32'h11);
        chk("same_grant0", 32'(grant), 32'b0100);
        chk("same_ready1", 32'(req_ready), 32'b1000);
        @(posedge clk); #1;
        req_valid = '0;
        @(negedge clk);
        chk("same_waddr1", 32'(waddr), 12);
        chk("same_wdata1", wdata, 32'h22);
        chk("same_grant1", 32'(grant), 32'b1000);

        // Reset mid-ARB with a write on the port and a request still pending.
        @(posedge clk); #1;
        set_req(0, 5'd3, 32'h77);
        @(posedge clk); #3;
        chk("midarb_we", 32'(we), 1);
        reset = 1'b0;
        #1;
        chk("midarb_rst_we", 32'(we), 0);
        chk("midarb_rst_waddr", 32'(waddr), 0);
        chk("midarb_rst_wdata", wdata, 0);
        chk("midarb_rst_grant", 32'(grant), 0);
        chk("midarb_rst_ready", 32'(req_ready), 0);
        req_valid = '0;
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
`ifdef RF_WRITE_CTRL_INIT_EN
        @(negedge clk);
        chk("rerun_waddr", 32'(waddr), 0);
        chk("rerun_done", 32'(done), 0);
`else
        chk("rerun_done", 32'(done), 1);
        chk("rerun_we", 32'(we), 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/regfile_write_ctrl.md
# regfile_write_ctrl

Write-port controller for the 32-entry register file. Owns the file's single write port: after reset it walks every register to its initial value (r29 = stack pointer, others zero), then shares the port between NREQ writeback requesters with round-robin arbitration and a valid/ready handshake. It sits between the writeback sources (ALU, load unit, multi-cycle units) and the register file's write-enable, write-address and write-data inputs.

## Interface
- N, 32, data width of the register file.
- NREQ, 4, number of writeback requesters (2..8).
- SP_INIT, 32'd252, init value of r29: top of data memory, byte address.
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- req_valid_i  input  NREQ  request i holds a pending write.
- req_rd_i  input  NREQ*5  destination index of request i, packed, request 0 in LSBs.
- req_data_i  input  NREQ*N  write data of request i, packed, request 0 in LSBs.
- req_ready_o  output  NREQ  one-hot accept; a transfer occurs when valid_i[i] & ready_o[i].
- Reg_Write_o  output  1  register-file write enable.
- Write_Register_o  output  5  register-file write index.
- Write_Data_o  output  N  register-file write data.
- grant_o  output  NREQ  registered one-hot copy of the last accepted requester, zero when idle.
- init_done_o  output  1  high once the init walk is complete.

## Operation
- FSM with two states, INIT and ARB. Reset enters INIT with a 5-bit counter at 0.
- INIT:
  - Each cycle, issue a write of index = counter, with data SP_INIT when counter==29, else 0.
  - Counter increments each cycle. After index 31 is issued, go to ARB and set init_done_o.
  - All req_ready_o are low in INIT.
- ARB:
  - Each cycle, pick the first valid requester starting at priority pointer ptr, wrapping modulo NREQ. Raise only its req_ready_o.
  - req_ready_o is combinational from req_valid_i and ptr.
  - On accept of requester i, ptr becomes (i+1) mod NREQ. With no valid requester, ptr holds and no write is issued.
- Requests with rd==0 are accepted (ready high, grant_o set) but produce no write. Reg_Write_o stays low, so r0 is never modified.
- Requesters hold valid, rd and data stable until accepted. Dropping valid before accept is legal, and that request is simply not granted.
- Two requesters targeting the same rd in consecutive cycles are written in grant order; the last write wins.
- Reset asserted mid-INIT or mid-ARB aborts immediately. The next release restarts INIT from index 0, and in-flight writes are discarded.

## Timing
- Reset values: Reg_Write_o 0, Write_Register_o 0, Write_Data_o 0, grant_o 0, init_done_o 0, ptr 0, req_ready_o 0.
- The write port is registered, giving 1-cycle latency. A decision made in cycle t drives Reg_Write_o, Write_Register_o and Write_Data_o in cycle t+1.
- Release reset in cycle 0:
  - Init writes of r0..r31 appear in cycles 1..32.
  - init_done_o rises in cycle 32.
  - First possible accept is in cycle 32, and its write appears in cycle 33.
- Throughput is one accepted write per cycle. A requester that stays valid waits at most NREQ-1 cycles for a grant.
- The Reg_Write_o, Write_Register_o and Write_Data_o outputs change only on clk or on reset assertion.

## Configuration
- Macro: RF_WRITE_CTRL_INIT_EN.
  - Defined: INIT walk as described above.
  - Undefined: INIT state and counter are not compiled. Reset enters ARB directly, init_done_o is tied high, and the first accept is possible in cycle 0. Register initial contents are then the register file's own reset values.

## Structure
- Package rf_ctrl_pkg:
  - State enum {INIT, ARB}.
  - REG_COUNT=32, ADDR_W=5, SP_REG=29, ZERO_REG=0.
- Sub-module rr_arbiter: NREQ-wide round-robin arbiter with pointer register. Inputs are the request vector and an enable; outputs are the one-hot grant and an update strobe.
- The top level holds the FSM, init counter, output registers and rd==0 suppression.

## Test plan
- Release reset with the macro defined: cycles 1..32 show writes to r0..r31, all with data 0 except r29=252. init_done_o rises in cycle 32.
- Single requester: req 2 valid, rd=5, data=32'hDEADBEEF in ARB. It is accepted the same cycle, and Reg_Write_o=1, Write_Register_o=5, Write_Data_o=32'hDEADBEEF appear the next cycle.
- All 4 requesters valid continuously from ptr=0: grants go 0,1,2,3,0, one per cycle, and grant_o matches one cycle later.
- Request with rd=0 and data=32'h1234: it is accepted, ready pulses, and Reg_Write_o stays 0 for that cycle.
- Reset asserted at INIT counter=10: all outputs return to 0 asynchronously. After release, the walk restarts at r0 and init_done_o does not rise until 32 cycles later.
- Macro undefined: init_done_o=1 out of reset, and req 0 valid in cycle 0 produces its write in cycle 1.
